// File: rtl/al422b_fifo_writer_if.sv
// Camera-side and FIFO-side signals of the AL422B write controller.
// The master side drives the sensor bus and capture; the slave side is the controller.
interface al422b_fifo_writer_if;
  logic        capture;
  logic        frame_valid;
  logic        line_valid;
  logic [7:0]  pix_data;
  logic [7:0]  fifo_di;
  logic        fifo_we_n;
  logic        fifo_wrst_n;
  logic        busy;
  logic        frame_done;
  logic        short_frame;
  logic        overflow;
  logic [18:0] wr_count;

  modport master (
    output capture, frame_valid, line_valid, pix_data,
    input  fifo_di, fifo_we_n, fifo_wrst_n, busy, frame_done, short_frame, overflow, wr_count
  );

  modport slave (
    input  capture, frame_valid, line_valid, pix_data,
    output fifo_di, fifo_we_n, fifo_wrst_n, busy, frame_done, short_frame, overflow, wr_count
  );
endinterface

// File: rtl/al422b_fifo_writer.sv
// Crops a fixed window out of the MT9V034 pixel stream and writes it, in raster
// order, into the AL422B frame FIFO; one frame per capture request.
module al422b_fifo_writer #(
  parameter int H_ACTIVE    = 384,
  parameter int V_ACTIVE    = 288,
  parameter int H_START     = 184,
  parameter int V_START     = 96,
  parameter int WRST_CYCLES = 4,
  parameter int FIFO_DEPTH  = 393216
) (
  input  logic clk,
  input  logic reset,
  al422b_fifo_writer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    WRST    = 3'd2,
    WAIT_FV = 3'd3,
    CAPTURE = 3'd4,
    DONE    = 3'd5
  } state_e;

  localparam logic [11:0] COL_LO      = 12'(H_START);
  localparam logic [11:0] COL_HI      = 12'(H_START + H_ACTIVE);
  localparam logic [11:0] ROW_LO      = 12'(V_START);
  localparam logic [11:0] ROW_HI      = 12'(V_START + V_ACTIVE);
  localparam logic [18:0] FRAME_BYTES = 19'(H_ACTIVE * V_ACTIVE);
  localparam logic [18:0] DEPTH       = 19'(FIFO_DEPTH);
  localparam logic [7:0]  WRST_LAST   = 8'(WRST_CYCLES - 1);

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    if (v == 12'hFFF) begin
      return v;
    end else begin
      return v + 12'd1;
    end
  endfunction

  state_e      state_q, state_d;
  logic        fv_q, fv_d;
  logic        lv_q, lv_d;
  logic [11:0] row_q, row_d;
  logic [11:0] col_q, col_d;
  logic [7:0]  wrst_cnt_q, wrst_cnt_d;
  logic [7:0]  fifo_di_q, fifo_di_d;
  logic        fifo_we_n_q, fifo_we_n_d;
  logic        fifo_wrst_n_q, fifo_wrst_n_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;
  logic        short_frame_q, short_frame_d;
  logic        overflow_q, overflow_d;
  logic [18:0] wr_count_q, wr_count_d;

  logic        lv_rise_s, lv_fall_s, fv_rise_s, fv_fall_s;
  logic [11:0] col_cur_s;
  logic        in_window_s;

  // Next-state, counter and output computation for the capture sequencer.
  always_comb begin
    state_d       = state_q;
    fv_d          = bus.frame_valid;
    lv_d          = bus.line_valid;
    row_d         = row_q;
    col_d         = col_q;
    wrst_cnt_d    = wrst_cnt_q;
    fifo_di_d     = fifo_di_q;
    fifo_we_n_d   = 1'b1;
    fifo_wrst_n_d = 1'b1;
    busy_d        = busy_q;
    frame_done_d  = 1'b0;
    short_frame_d = short_frame_q;
    overflow_d    = overflow_q;
    wr_count_d    = wr_count_q;

    lv_rise_s = bus.line_valid & ~lv_q;
    lv_fall_s = ~bus.line_valid & lv_q;
    fv_rise_s = bus.frame_valid & ~fv_q;
    fv_fall_s = ~bus.frame_valid & fv_q;
    // The pixel on the LINE_VALID rise cycle is column 0 of its line.
    col_cur_s   = lv_rise_s ? 12'd0 : col_q;
    in_window_s = (row_q >= ROW_LO) && (row_q < ROW_HI) &&
                  (col_cur_s >= COL_LO) && (col_cur_s < COL_HI);

    case (state_q)
      IDLE: begin
        if (bus.capture) begin
          state_d       = ARM;
          busy_d        = 1'b1;
          short_frame_d = 1'b0;
          overflow_d    = 1'b0;
          wr_count_d    = 19'd0;
        end else begin
          state_d = IDLE;
        end
      end
      ARM: begin
        if (!bus.frame_valid) begin
          state_d       = WRST;
          fifo_wrst_n_d = 1'b0;
          wrst_cnt_d    = 8'd0;
        end else begin
          state_d = ARM;
        end
      end
      WRST: begin
        if (wrst_cnt_q == WRST_LAST) begin
          state_d = WAIT_FV;
        end else begin
          fifo_wrst_n_d = 1'b0;
          wrst_cnt_d    = wrst_cnt_q + 8'd1;
        end
      end
      WAIT_FV: begin
        if (fv_rise_s) begin
          state_d = CAPTURE;
          row_d   = 12'd0;
          col_d   = 12'd0;
        end else begin
          state_d = WAIT_FV;
        end
      end
      CAPTURE: begin
        // A FRAME_VALID fall closes the frame even if LINE_VALID is still high.
        if (fv_fall_s) begin
          state_d       = DONE;
          frame_done_d  = 1'b1;
          short_frame_d = (wr_count_q < FRAME_BYTES);
        end else begin
          if (bus.line_valid) begin
            col_d = sat_inc(col_cur_s);
          end else begin
            col_d = col_q;
          end
          if (lv_fall_s) begin
            row_d = sat_inc(row_q);
          end else begin
            row_d = row_q;
          end
          if (bus.line_valid && in_window_s && !overflow_q) begin
            fifo_di_d   = bus.pix_data;
            fifo_we_n_d = 1'b0;
            wr_count_d  = wr_count_q + 19'd1;
            if ((wr_count_q + 19'd1) == DEPTH) begin
              overflow_d = 1'b1;
            end else begin
              overflow_d = overflow_q;
            end
          end else begin
            fifo_we_n_d = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, counters and all outputs are registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      fv_q          <= 1'b0;
      lv_q          <= 1'b0;
      row_q         <= 12'd0;
      col_q         <= 12'd0;
      wrst_cnt_q    <= 8'd0;
      fifo_di_q     <= 8'd0;
      fifo_we_n_q   <= 1'b1;
      fifo_wrst_n_q <= 1'b1;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      short_frame_q <= 1'b0;
      overflow_q    <= 1'b0;
      wr_count_q    <= 19'd0;
    end else begin
      state_q       <= state_d;
      fv_q          <= fv_d;
      lv_q          <= lv_d;
      row_q         <= row_d;
      col_q         <= col_d;
      wrst_cnt_q    <= wrst_cnt_d;
      fifo_di_q     <= fifo_di_d;
      fifo_we_n_q   <= fifo_we_n_d;
      fifo_wrst_n_q <= fifo_wrst_n_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      short_frame_q <= short_frame_d;
      overflow_q    <= overflow_d;
      wr_count_q    <= wr_count_d;
    end
  end

  assign bus.fifo_di     = fifo_di_q;
  assign bus.fifo_we_n   = fifo_we_n_q;
  assign bus.fifo_wrst_n = fifo_wrst_n_q;
  assign bus.busy        = busy_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.short_frame = short_frame_q;
  assign bus.overflow    = overflow_q;
  assign bus.wr_count    = wr_count_q;

endmodule

// File: tb/tb_al422b_fifo_writer.sv
// Bench for al422b_fifo_writer: a scaled sensor geometry drives two instances
// (roomy FIFO and a tiny FIFO that overflows) against a scoreboard model.
module tb_al422b_fifo_writer;
  localparam int HA = 10;
  localparam int VA = 5;
  localparam int HS = 4;
  localparam int VS = 3;
  localparam int WC = 4;
  localparam int DA = 393216;
  localparam int DB = 23;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cap = 1'b0;
  logic       fv = 1'b0;
  logic       lv = 1'b0;
  logic [7:0] pix = 8'h00;
  int         cyc = 0;

  al422b_fifo_writer_if ifa();
  al422b_fifo_writer_if ifb();

  assign ifa.capture = cap;     assign ifb.capture = cap;
  assign ifa.frame_valid = fv;  assign ifb.frame_valid = fv;
  assign ifa.line_valid = lv;   assign ifb.line_valid = lv;
  assign ifa.pix_data = pix;    assign ifb.pix_data = pix;

  al422b_fifo_writer #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_START(HS), .V_START(VS),
                       .WRST_CYCLES(WC), .FIFO_DEPTH(DA))
    dut_a (.clk(clk), .reset(reset), .bus(ifa));
  al422b_fifo_writer #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_START(HS), .V_START(VS),
                       .WRST_CYCLES(WC), .FIFO_DEPTH(DB))
    dut_b (.clk(clk), .reset(reset), .bus(ifb));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cyc; logic [7:0] data;} wr_t;
  wr_t qa[$];
  wr_t qb[$];
  int  ecnt[2] = '{0, 0};
  int  pc[2] = '{0, 0};
  int  wrst_cnt[2] = '{0, 0};
  bit  short_m[2] = '{1'b0, 1'b0};
  bit  busy_m = 1'b0;
  bit  capturing = 1'b0;
  int  cap_cyc = -1;
  int  done_cyc = -1;
  int  n_chk = 0;
  int  n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison of one instance against the scoreboard.
  task automatic check_dut(input int i, input logic we_n, input logic wrst_n, input logic [7:0] di,
                           input logic [18:0] wc, input logic ovf, input logic sh,
                           input logic fd, input logic bsy);
    bit         hit;
    logic [7:0] ed;
    int         depth;
    hit = 1'b0;
    ed = 8'h00;
    depth = (i == 0) ? DA : DB;
    if (i == 0) begin
      if (qa.size() > 0 && qa[0].cyc == cyc) begin
        hit = 1'b1; ed = qa[0].data; void'(qa.pop_front());
      end
    end else begin
      if (qb.size() > 0 && qb[0].cyc == cyc) begin
        hit = 1'b1; ed = qb[0].data; void'(qb.pop_front());
      end
    end
    chk($sformatf("we_n[%0d]", i), we_n, !hit);
    if (hit) begin
      chk($sformatf("di[%0d]", i), di, ed);
      pc[i]++;
    end
    if (!wrst_n) wrst_cnt[i]++;
    chk($sformatf("we_wrst_excl[%0d]", i), we_n | wrst_n, 1);
    if (!busy_m) chk($sformatf("wrst_idle[%0d]", i), wrst_n, 1);
    chk($sformatf("wr_count[%0d]", i), wc, pc[i]);
    chk($sformatf("overflow[%0d]", i), ovf, pc[i] >= depth);
    if (cyc == done_cyc) begin
      short_m[i] = (pc[i] < HA * VA);
      chk($sformatf("wrst_len[%0d]", i), wrst_cnt[i], WC);
    end
    chk($sformatf("short_frame[%0d]", i), sh, short_m[i]);
    chk($sformatf("frame_done[%0d]", i), fd, cyc == done_cyc);
    chk($sformatf("busy[%0d]", i), bsy, busy_m);
  endtask

  // The single compare process.
  always @(negedge clk) begin
    if (reset) begin
      if (cyc == cap_cyc) begin
        busy_m = 1'b1; pc = '{0, 0}; short_m = '{1'b0, 1'b0}; wrst_cnt = '{0, 0};
      end
      check_dut(0, ifa.fifo_we_n, ifa.fifo_wrst_n, ifa.fifo_di, ifa.wr_count, ifa.overflow,
                ifa.short_frame, ifa.frame_done, ifa.busy);
      check_dut(1, ifb.fifo_we_n, ifb.fifo_wrst_n, ifb.fifo_di, ifb.wr_count, ifb.overflow,
                ifb.short_frame, ifb.frame_done, ifb.busy);
      if (cyc == done_cyc) busy_m = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      fv = 1'b0; lv = 1'b0; step();
    end
  endtask

  task automatic pulse_capture(input bit accept);
    cap = 1'b1;
    if (accept) begin
      cap_cyc = cyc + 1;
      ecnt = '{0, 0};
    end
    step();
    cap = 1'b0;
  endtask

  task automatic check_reset_vals();
    chk("rst_we_n", ifa.fifo_we_n, 1);
    chk("rst_wrst_n", ifa.fifo_wrst_n, 1);
    chk("rst_di", ifa.fifo_di, 0);
    chk("rst_busy", ifa.busy, 0);
    chk("rst_frame_done", ifa.frame_done, 0);
    chk("rst_short", ifa.short_frame, 0);
    chk("rst_overflow", ifa.overflow, 0);
    chk("rst_wr_count", ifa.wr_count, 0);
    chk("rst_wr_count_b", ifb.wr_count, 0);
    chk("rst_overflow_b", ifb.overflow, 0);
  endtask

  task automatic mid_reset();
    reset = 1'b0;
    #1;
    qa.delete(); qb.delete();
    capturing = 1'b0; busy_m = 1'b0; pc = '{0, 0}; ecnt = '{0, 0};
    short_m = '{1'b0, 1'b0}; wrst_cnt = '{0, 0}; done_cyc = -1; cap_cyc = -1;
    check_reset_vals();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic push_pix(input int r, input int c, input logic [7:0] d);
    if (capturing && r >= VS && r < VS + VA && c >= HS && c < HS + HA) begin
      if (ecnt[0] < DA) begin qa.push_back(wr_t'{cyc + 1, d}); ecnt[0]++; end
      if (ecnt[1] < DB) begin qb.push_back(wr_t'{cyc + 1, d}); ecnt[1]++; end
    end
  endtask

  // end_mode: 0 = LV drops before FV, 1 = LV and FV drop together, 2 = FV drops with LV high.
  // evt_kind at the first blanking cycle of evt_row: 1 = accepted capture, 2 = reset, 3 = ignored capture.
  task automatic send_frame(input int lines, input int cols, input bit cap_this,
                            input int evt_row, input int evt_kind, input int end_mode);
    fv = 1'b1; lv = 1'b0; capturing = cap_this;
    step(); step(); step();
    for (int r = 0; r < lines; r++) begin
      for (int b = 0; b < 3; b++) begin
        lv = 1'b0;
        if (r == evt_row && b == 0 && evt_kind == 1) pulse_capture(1'b1);
        else if (r == evt_row && b == 0 && evt_kind == 3) pulse_capture(1'b0);
        else if (r == evt_row && b == 0 && evt_kind == 2) mid_reset();
        else step();
      end
      for (int c = 0; c < cols; c++) begin
        lv = 1'b1;
        pix = 8'((c + 16 * r) & 255);
        push_pix(r, c, pix);
        step();
      end
    end
    if (end_mode == 0) begin
      lv = 1'b0; step(); step();
    end
    fv = 1'b0;
    lv = (end_mode == 2);
    pix = 8'hEE;
    if (capturing) begin
      done_cyc = cyc + 1;
      capturing = 1'b0;
    end
    step();
    idle(8);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    reset = 1'b1;
    step(); step();

    // Full frame, longer lines and extra lines truncated; instance B overflows at 23.
    pulse_capture(1'b1); idle(8);
    send_frame(12, 20, 1'b1, -1, 0, 0);
    chk("t1_wr_count", ifa.wr_count, 50);
    chk("t1_short", ifa.short_frame, 0);
    chk("t1_overflow", ifa.overflow, 0);
    chk("t4_wr_count_b", ifb.wr_count, 23);
    chk("t4_overflow_b", ifb.overflow, 1);

    // Capture during a frame: that frame is skipped, the next one captured.
    send_frame(12, 20, 1'b0, 5, 1, 0);
    send_frame(12, 20, 1'b1, -1, 0, 0);
    chk("t2_wr_count", ifa.wr_count, 50);

    // Too few lines, then too-short lines.
    pulse_capture(1'b1); idle(8);
    send_frame(6, 20, 1'b1, -1, 0, 0);
    chk("t3_wr_count", ifa.wr_count, 30);
    chk("t3_short", ifa.short_frame, 1);
    pulse_capture(1'b1); idle(8);
    send_frame(12, 9, 1'b1, -1, 0, 0);
    chk("t3b_wr_count", ifa.wr_count, 25);

    // Reset mid-capture, then a clean frame.
    pulse_capture(1'b1); idle(8);
    send_frame(12, 20, 1'b1, 5, 2, 0);
    chk("t5_idle_busy", ifa.busy, 0);
    pulse_capture(1'b1); idle(8);
    send_frame(12, 20, 1'b1, -1, 0, 0);
    chk("t5_wr_count", ifa.wr_count, 50);

    // Ignored re-capture, LV/FV falling together right after an in-window pixel.
    pulse_capture(1'b1); idle(8);
    send_frame(8, 14, 1'b1, 2, 3, 1);
    chk("t6_wr_count", ifa.wr_count, 50);
    chk("t6_short", ifa.short_frame, 0);

    // FV falls while LV is still high: that sample is not written.
    pulse_capture(1'b1); idle(8);
    send_frame(8, 14, 1'b1, -1, 0, 2);
    chk("t6b_wr_count", ifa.wr_count, 50);
    chk("t6b_busy", ifa.busy, 0);

    chk("end_queue_a", qa.size(), 0);
    chk("end_queue_b", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/al422b_fifo_writer.md
Name: al422b_fifo_writer

Overview:
Write-side controller for the AL422B frame FIFO on the stereo camera breakout. It samples the MT9V034 parallel pixel bus (FRAME_VALID, LINE_VALID, 8-bit data) in the camera sysclk domain. It crops a fixed window and drives the FIFO write port (DI, WE_N, WRST_N). It is the producer counterpart of the FIFO read path in imgbuf: a read of a completed frame returns exactly the cropped window, in raster order.

Parameters:
H_ACTIVE, 384, cropped columns written per line
V_ACTIVE, 288, cropped lines written per frame
H_START, 184, first sensor column kept (0-based, counted from LINE_VALID rise)
V_START, 96, first sensor line kept (0-based, counted from FRAME_VALID rise)
WRST_CYCLES, 4, cycles WRST_N is held low before a capture
FIFO_DEPTH, 393216, AL422B capacity in bytes

Ports:
clk  input  1  camera sysclk domain; all logic on rising edge
reset  input  1  asynchronous, active-low reset
capture  input  1  single-cycle request to capture the next full frame
frame_valid  input  1  sensor FRAME_VALID, synchronous to clk
line_valid  input  1  sensor LINE_VALID, synchronous to clk
pix_data  input  8  sensor pixel data, valid when line_valid=1
fifo_di  output  8  AL422B DI[7:0]
fifo_we_n  output  1  AL422B write enable, active low
fifo_wrst_n  output  1  AL422B write-pointer reset, active low
busy  output  1  high from accepted capture until DONE
frame_done  output  1  one-cycle pulse when a frame is committed
short_frame  output  1  sticky until next capture; frame ended with fewer than H_ACTIVE*V_ACTIVE writes
overflow  output  1  sticky until next capture; write count hit FIFO_DEPTH
wr_count  output  19  bytes written in the current or last frame

Behaviour:
- Reset (reset=0, async) forces:
  - state=IDLE
  - fifo_di=0, fifo_we_n=1, fifo_wrst_n=1
  - busy=0, frame_done=0, short_frame=0, overflow=0, wr_count=0
  - all row and column counters cleared
- Reset asserted mid-frame abandons the frame. After release, the block waits in IDLE for a new capture; nothing resumes.
- FSM states: IDLE, ARM, WRST, WAIT_FV, CAPTURE, DONE.
  - IDLE: capture=1 -> ARM. On the same cycle: busy=1, short_frame=0, overflow=0, wr_count=0.
  - ARM: wait for frame_valid=0, so a frame already in progress is never captured partially -> WRST.
  - WRST: fifo_wrst_n=0 for exactly WRST_CYCLES cycles -> WAIT_FV.
  - WAIT_FV: on frame_valid rising edge -> CAPTURE, row=0.
  - CAPTURE: on frame_valid falling edge -> DONE.
  - DONE: frame_done=1 for one cycle; short_frame = (wr_count < H_ACTIVE*V_ACTIVE); busy=0 -> IDLE.
- capture while busy=1 is ignored and has no effect on the frame in progress.
- Edge detection uses a one-cycle registered copy of frame_valid and line_valid.
- Counters in CAPTURE:
  - col: cleared on line_valid rise; increments each cycle line_valid=1.
  - row: increments on each line_valid fall.
  - Both saturate at their maximum value and never wrap.
- Write qualify:
  - condition: line_valid=1 AND V_START <= row < V_START+V_ACTIVE AND H_START <= col < H_START+H_ACTIVE AND overflow=0.
  - Latency is one cycle: fifo_di <= pix_data and fifo_we_n <= ~qualify, both registered. fifo_di holds its last value when not writing.
  - wr_count increments on each qualified write.
- Overflow: if wr_count reaches FIFO_DEPTH, overflow=1 and all further writes in this frame are suppressed. The FSM still waits for the frame_valid fall, then goes to DONE normally.
- A sensor line longer than H_START+H_ACTIVE is truncated. Frames with extra lines are truncated at V_START+V_ACTIVE.
- A line shorter than H_START+H_ACTIVE produces fewer writes. It is not padded; this is detected by short_frame.
- frame_valid falling while line_valid=1 ends the line and the frame on the same cycle.
- Output guarantee: fifo_we_n=0 and fifo_wrst_n=0 are never asserted in the same cycle.

Test Plan:
1. Reset is released, then capture is pulsed with frame_valid=0. Sensor model sends a 752x480 frame, pixel value = col[7:0]. -> fifo_wrst_n is low 4 cycles; exactly 110592 fifo_we_n low cycles; the first byte written is 184 (0xB8) on sensor row 96; frame_done pulses once; short_frame=0; wr_count=110592.
2. capture is pulsed mid-frame (frame_valid=1). -> Block stays in ARM until frame_valid falls, then captures only the next frame; zero writes during the partial frame.
3. Sensor sends 752x200 lines. -> wr_count=384*104=39936; short_frame=1 at frame_done.
4. FIFO_DEPTH=1000 override with a full frame. -> Writes stop at wr_count=1000; overflow=1; frame_done still pulses after the frame_valid fall.
5. reset is driven low at row 150 of CAPTURE, then released, then a new capture is issued. -> All outputs return to reset values immediately; the next frame yields the full 110592 writes.
6. capture is re-pulsed while busy=1, and line_valid drops together with frame_valid. -> The extra request is ignored; exactly one frame_done pulse; no write on the cycle after frame_valid falls.
